// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor/call types and dispatcher state encoding
package elevator_pkg;
    localparam int NUM_FLOORS = 5;
    localparam int FLOOR_W = 3;
    typedef logic [FLOOR_W-1:0] floor_t;
    typedef struct packed {
        floor_t origin;
        floor_t dest;
    } call_t;
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE} dispatch_state_t;
    function automatic logic call_ok(call_t c);
        return c.origin < floor_t'(NUM_FLOORS) && c.dest < floor_t'(NUM_FLOORS) && c.origin != c.dest;
    endfunction
endpackage

// File: rtl/call_fifo.sv
// call_fifo: DEPTH-entry circular buffer of call requests with occupancy count
module call_fifo
    import elevator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  call_t                      data_i,
    input  logic                       pop_i,
    output call_t                      head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    call_t mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic do_push, do_pop;
    assign full_o = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop = pop_i && !empty_o;
    assign head_o = mem_q[rd_q];
    assign count_o = count_q;
    // entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher: validates and queues calls, issues them one at a time to the elevator
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int EN_CYCLES = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic [FLOOR_W-1:0]         req_origin,
    input  logic [FLOOR_W-1:0]         req_dest,
    output logic                       req_ready,
    output logic                       req_err,
    input  logic                       estop_btn,
    input  logic                       idle,
    output logic [FLOOR_W-1:0]         in_origin,
    output logic [FLOOR_W-1:0]         destination,
    output logic                       en,
    output logic                       emergency_stop,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       busy
);
    localparam int TW = $clog2(BUSY_TIMEOUT);
    dispatch_state_t state_q;
    logic [TW-1:0] timer_q;
    logic en_q, err_q, estop_q, full, empty, push, pop;
    floor_t origin_q, dest_q;
    call_t req_c, head;
    assign req_c = '{origin: req_origin, dest: req_dest};
    assign req_ready = !reset && !full;
    assign push = req_valid && req_ready && call_ok(req_c);
    assign pop = state_q == S_IDLE && !empty && !estop_btn;
    assign in_origin = origin_q;
    assign destination = dest_q;
    assign en = en_q;
    assign req_err = err_q;
    assign emergency_stop = estop_q;
    assign busy = state_q != S_IDLE;
    call_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .push_i (push),
        .data_i (req_c),
        .pop_i  (pop),
        .head_o (head),
        .count_o(q_count),
        .full_o (full),
        .empty_o(empty)
    );
    // rejection pulse and emergency-stop register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            estop_q <= 1'b0;
        end else begin
            err_q <= req_valid && req_ready && !call_ok(req_c);
            estop_q <= estop_btn;
        end
    end
    // dispatch FSM; timer counts launch cycles then busy-wait cycles; everything freezes on estop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            en_q <= 1'b0;
            origin_q <= '0;
            dest_q <= '0;
        end else if (!estop_btn) begin
            case (state_q)
                S_IDLE: if (pop) begin
                    origin_q <= head.origin;
                    dest_q <= head.dest;
                    en_q <= 1'b1;
                    timer_q <= '0;
                    state_q <= S_LAUNCH;
                end
                S_LAUNCH: if (timer_q == TW'(EN_CYCLES - 1)) begin
                    en_q <= 1'b0;
                    timer_q <= '0;
                    state_q <= S_WAIT_BUSY;
                end else timer_q <= timer_q + 1'b1;
                S_WAIT_BUSY: if (!idle) state_q <= S_WAIT_DONE;
                else if (timer_q == TW'(BUSY_TIMEOUT - 1)) state_q <= S_IDLE;
                else timer_q <= timer_q + 1'b1;
                S_WAIT_DONE: if (idle) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// tb_elevator_call_dispatcher: directed scenario tests for the call dispatcher
module tb_elevator_call_dispatcher;
    import elevator_pkg::*;
    logic clk = 1'b0;
    logic reset, req_valid, estop_btn, idle;
    logic [2:0] req_origin, req_dest;
    logic req_ready, req_err, en, emergency_stop, busy;
    logic [2:0] in_origin, destination, q_count;
    int total = 0;
    int bad = 0;
    logic [2:0] eo [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
    logic [2:0] ed [4] = '{3'd2, 3'd4, 3'd1, 3'd0};

    elevator_call_dispatcher dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_origin(req_origin), .req_dest(req_dest),
        .req_ready(req_ready), .req_err(req_err), .estop_btn(estop_btn), .idle(idle),
        .in_origin(in_origin), .destination(destination), .en(en), .emergency_stop(emergency_stop),
        .q_count(q_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] o, input logic [2:0] d);
        req_valid = v;
        req_origin = o;
        req_dest = d;
    endtask

    task automatic test_reset;
        reset = 1'b1; estop_btn = 1'b0; idle = 1'b1; drive(0, 0, 0);
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready act=%b exp=0", req_ready); end
        total++; if (en !== 1'b0 || busy !== 1'b0 || q_count !== 3'd0) begin bad++; $display("FAIL rst_state en=%b busy=%b cnt=%0d exp 0/0/0", en, busy, q_count); end
        @(negedge clk);
        total++; if (in_origin !== 3'd0 || destination !== 3'd0 || req_err !== 1'b0 || emergency_stop !== 1'b0) begin bad++; $display("FAIL rst_outs org=%0d dst=%0d err=%b es=%b exp all 0", in_origin, destination, req_err, emergency_stop); end
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after act=%b exp=1", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_single;
        idle = 1'b1; drive(1, 4, 0);
        @(negedge clk); drive(0, 0, 0);
        total++; if (q_count !== 3'd1 || en !== 1'b0) begin bad++; $display("FAIL t1_push cnt=%0d en=%b exp 1/0", q_count, en); end
        @(negedge clk);
        total++; if (en !== 1'b1 || in_origin !== 3'd4 || destination !== 3'd0) begin bad++; $display("FAIL t1_launch en=%b org=%0d dst=%0d exp 1/4/0", en, in_origin, destination); end
        total++; if (q_count !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL t1_pop cnt=%0d busy=%b exp 0/1", q_count, busy); end
        @(negedge clk);
        total++; if (en !== 1'b1) begin bad++; $display("FAIL t1_en2 act=%b exp=1", en); end
        @(negedge clk);
        total++; if (en !== 1'b0) begin bad++; $display("FAIL t1_en3 act=%b exp=0", en); end
        idle = 1'b0; @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_moving busy=%b exp=1", busy); end
        idle = 1'b1; @(negedge clk);
        total++; if (busy !== 1'b0 || q_count !== 3'd0) begin bad++; $display("FAIL t1_retire busy=%b cnt=%0d exp 0/0", busy, q_count); end
    endtask

    task automatic test_back_to_back;
        idle = 1'b0;
        drive(1, 1, 3); @(negedge clk);
        drive(1, 0, 2); @(negedge clk);
        total++; if (en !== 1'b1 || in_origin !== 3'd1 || destination !== 3'd3 || q_count !== 3'd1) begin bad++; $display("FAIL t2_first en=%b org=%0d dst=%0d cnt=%0d exp 1/1/3/1", en, in_origin, destination, q_count); end
        drive(1, 2, 4); @(negedge clk);
        drive(1, 3, 1); @(negedge clk);
        drive(1, 4, 0); @(negedge clk);
        total++; if (q_count !== 3'd4 || req_ready !== 1'b0) begin bad++; $display("FAIL t2_full cnt=%0d ready=%b exp 4/0", q_count, req_ready); end
        drive(1, 1, 2); repeat (3) @(negedge clk);
        total++; if (q_count !== 3'd4 || busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL t2_stall cnt=%0d busy=%b ready=%b exp 4/1/0", q_count, busy, req_ready); end
        drive(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            idle = 1'b1;
            for (int i = 0; i < 20 && en !== 1'b1; i++) @(negedge clk);
            total++; if (en !== 1'b1 || in_origin !== eo[k] || destination !== ed[k] || q_count !== 3'(3 - k)) begin bad++; $display("FAIL t2_order%0d en=%b org=%0d dst=%0d cnt=%0d exp 1/%0d/%0d/%0d", k, en, in_origin, destination, q_count, eo[k], ed[k], 3 - k); end
            for (int i = 0; i < 20 && en !== 1'b0; i++) @(negedge clk);
            idle = 1'b0; @(negedge clk);
        end
        idle = 1'b1; repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || q_count !== 3'd0) begin bad++; $display("FAIL t2_drain busy=%b cnt=%0d exp 0/0", busy, q_count); end
    endtask

    task automatic test_invalid;
        int errs = 0;
        logic saw_en = 1'b0;
        idle = 1'b1;
        drive(1, 4, 4); @(negedge clk); drive(0, 0, 0);
        total++; if (req_err !== 1'b1 || q_count !== 3'd0) begin bad++; $display("FAIL t3_same err=%b cnt=%0d exp 1/0", req_err, q_count); end
        @(negedge clk);
        total++; if (req_err !== 1'b0) begin bad++; $display("FAIL t3_pulse1 err=%b exp=0", req_err); end
        drive(1, 5, 1); @(negedge clk); drive(0, 0, 0);
        total++; if (req_err !== 1'b1 || q_count !== 3'd0) begin bad++; $display("FAIL t3_range err=%b cnt=%0d exp 1/0", req_err, q_count); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_err === 1'b1) errs++;
            if (en !== 1'b0) saw_en = 1'b1;
        end
        total++; if (errs != 0 || saw_en !== 1'b0 || q_count !== 3'd0) begin bad++; $display("FAIL t3_quiet extra_err=%0d en_seen=%b cnt=%0d exp 0/0/0", errs, saw_en, q_count); end
    endtask

    task automatic test_timeout;
        idle = 1'b1;
        drive(1, 0, 2); @(negedge clk);
        drive(1, 2, 4); @(negedge clk); drive(0, 0, 0);
        total++; if (q_count !== 3'd1 || en !== 1'b1 || in_origin !== 3'd0) begin bad++; $display("FAIL t4_pushpop cnt=%0d en=%b org=%0d exp 1/1/0", q_count, en, in_origin); end
        repeat (2) @(negedge clk);
        total++; if (en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL t4_endrop en=%b busy=%b exp 0/1", en, busy); end
        repeat (15) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_early busy=%b exp=1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || en !== 1'b0) begin bad++; $display("FAIL t4_timeout busy=%b en=%b exp 0/0", busy, en); end
        @(negedge clk);
        total++; if (en !== 1'b1 || in_origin !== 3'd2 || destination !== 3'd4 || q_count !== 3'd0) begin bad++; $display("FAIL t4_next en=%b org=%0d dst=%0d cnt=%0d exp 1/2/4/0", en, in_origin, destination, q_count); end
        repeat (2) @(negedge clk);
        idle = 1'b0; @(negedge clk);
        idle = 1'b1; @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_clean busy=%b exp=0", busy); end
    endtask

    task automatic test_estop;
        logic moved = 1'b0;
        idle = 1'b1;
        drive(1, 1, 4); @(negedge clk);
        drive(1, 3, 0); @(negedge clk); drive(0, 0, 0);
        repeat (2) @(negedge clk);
        total++; if (en !== 1'b0 || busy !== 1'b1 || q_count !== 3'd1) begin bad++; $display("FAIL t5_setup en=%b busy=%b cnt=%0d exp 0/1/1", en, busy, q_count); end
        estop_btn = 1'b1; #1;
        total++; if (emergency_stop !== 1'b0) begin bad++; $display("FAIL t5_es_delay act=%b exp=0", emergency_stop); end
        @(negedge clk);
        total++; if (emergency_stop !== 1'b1) begin bad++; $display("FAIL t5_es_on act=%b exp=1", emergency_stop); end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || en !== 1'b0 || q_count !== 3'd1) moved = 1'b1;
        end
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL t5_frozen moved=%b exp=0", moved); end
        estop_btn = 1'b0; #1;
        total++; if (emergency_stop !== 1'b1) begin bad++; $display("FAIL t5_es_hold act=%b exp=1", emergency_stop); end
        @(negedge clk);
        total++; if (emergency_stop !== 1'b0) begin bad++; $display("FAIL t5_es_off act=%b exp=0", emergency_stop); end
        repeat (14) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_early busy=%b exp=1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_timeout busy=%b exp=0", busy); end
        @(negedge clk);
        total++; if (en !== 1'b1 || in_origin !== 3'd3 || destination !== 3'd0) begin bad++; $display("FAIL t5_next en=%b org=%0d dst=%0d exp 1/3/0", en, in_origin, destination); end
        repeat (2) @(negedge clk);
        idle = 1'b0; @(negedge clk);
        idle = 1'b1; @(negedge clk);
    endtask

    task automatic test_reset_mid;
        idle = 1'b1; estop_btn = 1'b1;
        drive(1, 1, 2); @(negedge clk);
        drive(1, 2, 3); @(negedge clk);
        drive(1, 3, 4); @(negedge clk);
        drive(1, 4, 0); @(negedge clk); drive(0, 0, 0);
        total++; if (q_count !== 3'd4 || busy !== 1'b0 || en !== 1'b0) begin bad++; $display("FAIL t6_hold cnt=%0d busy=%b en=%b exp 4/0/0", q_count, busy, en); end
        estop_btn = 1'b0; @(negedge clk);
        total++; if (en !== 1'b1 || q_count !== 3'd3 || in_origin !== 3'd1) begin bad++; $display("FAIL t6_launch en=%b cnt=%0d org=%0d exp 1/3/1", en, q_count, in_origin); end
        reset = 1'b1; #1;
        total++; if (en !== 1'b0 || busy !== 1'b0 || q_count !== 3'd0 || req_ready !== 1'b0) begin bad++; $display("FAIL t6_async en=%b busy=%b cnt=%0d ready=%b exp 0/0/0/0", en, busy, q_count, req_ready); end
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (en !== 1'b0 || busy !== 1'b0 || q_count !== 3'd0 || req_ready !== 1'b1) begin bad++; $display("FAIL t6_quiet en=%b busy=%b cnt=%0d ready=%b exp 0/0/0/1", en, busy, q_count, req_ready); end
        drive(1, 2, 0); @(negedge clk); drive(0, 0, 0);
        @(negedge clk);
        total++; if (en !== 1'b1 || in_origin !== 3'd2 || destination !== 3'd0) begin bad++; $display("FAIL t6_new en=%b org=%0d dst=%0d exp 1/2/0", en, in_origin, destination); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_invalid;
        test_timeout;
        test_estop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
